// File: rtl/msrv32_integer_rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_pkg
// Description : Shared types and constants for the RV32I integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] RF_X0   = 5'd0;
  localparam logic [REG_ADDR_W-1:0] RF_LAST = 5'd31;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage : msrv32_pkg
`default_nettype wire

// File: rtl/msrv32_integer_rf_wb.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_integer_rf_wb
// Description : RV32I integer register file (2R/1W) fed by the writeback mux,
//               with a post-reset sweep that zeroes x1..x31 one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_integer_rf_wb
  import msrv32_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic                  rf_wr_en_reg_in,
  input  logic                  flush_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_reg_in,
  input  logic [DATA_WIDTH-1:0] wb_mux_data_in,
  input  logic [ADDR_WIDTH-1:0] rs_1_addr_in,
  input  logic [ADDR_WIDTH-1:0] rs_2_addr_in,
  output logic [DATA_WIDTH-1:0] rs_1_out,
  output logic [DATA_WIDTH-1:0] rs_2_out,
  output logic                  rf_busy_out
);

  localparam int                    c_NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST  = {ADDR_WIDTH{1'b1}};

  rf_state_t               r_state;
  rf_state_t               w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_sweep_cnt;
  logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_array [1:c_NREGS-1];

  logic                    w_wb_we;
  logic                    w_arr_we;
  logic [ADDR_WIDTH-1:0]   w_arr_addr;
  logic [DATA_WIDTH-1:0]   w_arr_data;

  assign w_wb_we = rf_wr_en_reg_in & ~flush_in & (rd_addr_reg_in != '0);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    r_state     <= w_state_nxt;
    r_sweep_cnt <= w_cnt_nxt;
  end

  // Single array write port shared by the clear sweep and pipeline writeback.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_sweep_cnt;
    w_arr_we    = 1'b0;
    w_arr_addr  = r_sweep_cnt;
    w_arr_data  = '0;
    case (r_state)
      RF_INIT: begin
        w_arr_we  = 1'b1;
        w_cnt_nxt = r_sweep_cnt + c_FIRST;
        if (r_sweep_cnt == c_LAST) begin
          w_state_nxt = RF_RUN;
        end
      end
      RF_RUN: begin
        w_arr_we   = w_wb_we;
        w_arr_addr = rd_addr_reg_in;
        w_arr_data = wb_mux_data_in;
      end
      default: begin
        w_state_nxt = RF_INIT;
      end
    endcase
    if (!ms_riscv32_mp_rst_in) begin
      w_state_nxt = RF_INIT;
      w_cnt_nxt   = c_FIRST;
      w_arr_we    = 1'b0;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_arr_we) begin
      r_array[w_arr_addr] <= w_arr_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] i_addr);
    logic [DATA_WIDTH-1:0] w_val;
    w_val = '0;
    if (r_state == RF_RUN && i_addr != '0) begin
      if (BYPASS_EN && w_wb_we && (i_addr == rd_addr_reg_in)) begin
        w_val = wb_mux_data_in;
      end else begin
        w_val = r_array[i_addr];
      end
    end
    return w_val;
  endfunction

  always_comb begin
    rs_1_out = f_read(rs_1_addr_in);
    rs_2_out = f_read(rs_2_addr_in);
  end

  assign rf_busy_out = (r_state == RF_INIT);

endmodule : msrv32_integer_rf_wb
`default_nettype wire

// File: tb/tb_msrv32_integer_rf_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrv32_integer_rf_wb
// Description : Directed, table-driven bench for the integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_integer_rf_wb;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        flush;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic        busy;

  int n_vec;
  int n_err;

  msrv32_integer_rf_wb #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .BYPASS_EN (1'b1)
  ) u_dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .rf_wr_en_reg_in     (wr_en),
    .flush_in            (flush),
    .rd_addr_reg_in      (rd),
    .wb_mux_data_in      (wdata),
    .rs_1_addr_in        (rs1),
    .rs_2_addr_in        (rs2),
    .rs_1_out            (rs1_out),
    .rs_2_out            (rs2_out),
    .rf_busy_out         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        fl;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic fl, input logic [4:0] d_rd,
                       input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
    wr_en = we; flush = fl; rd = d_rd; wdata = d; rs1 = a1; rs2 = a2;
  endtask

  // Counts edges from reset release until busy falls; writes to x3 are
  // requested throughout and read port 1 must stay at zero.
  task automatic sweep(input string name, output int edges);
    edges = 0;
    drive(1'b1, 1'b0, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd31);
    while (busy === 1'b1 && edges < 40) begin
      if (edges == 5) chk({name, "_init_rd"}, rs1_out, 32'h0);
      @(posedge clk); #1;
      edges++;
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
  endtask

  initial begin
    int edges;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF, 5'd3,  5'd5,  32'h0,         32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h1234_5678, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 5'd7,  32'h0000_0011, 5'd7,  5'd1,  32'h0000_0011, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,  32'h0000_0011, 32'h0000_0011};
    vecs[6]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h0000_0011, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 5'd31, 32'h8000_0001, 5'd31, 5'd31, 32'h8000_0001, 32'h8000_0001};
    vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h8000_0001, 32'h8000_0001};
    vecs[9]  = '{1'b1, 1'b0, 5'd20, 32'hCAFE_F00D, 5'd20, 5'd3,  32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd20, 5'd7,  32'hCAFE_F00D, 32'h0000_0011};
    vecs[11] = '{1'b0, 1'b0, 5'd6,  32'h0000_0055, 5'd6,  5'd2,  32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  32'h0,         5'd6,  5'd31, 32'h0,         32'h8000_0001};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
    #1;
    chk("reset_rs1", rs1_out, 32'h0);
    chk("reset_rs2", rs2_out, 32'h0);

    rst_n = 1'b1;
    sweep("sweep1", edges);
    chk("sweep1_edges", 32'(edges), 32'd31);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
    #1;
    chk("post_sweep_x5", rs1_out, 32'h0);
    chk("post_sweep_x3", rs2_out, 32'h0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].we, vecs[i].fl, vecs[i].rd, vecs[i].d, vecs[i].a1, vecs[i].a2);
      #2;
      chk($sformatf("vec%0d_rs1", i), rs1_out, vecs[i].e1);
      chk($sformatf("vec%0d_rs2", i), rs2_out, vecs[i].e2);
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
    end

    // Reset pulsed after 10 sweep edges: sweep must restart from x1.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("restart1_busy", {31'h0, busy}, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sweep("sweep2", edges);
    chk("sweep2_edges", 32'(edges), 32'd31);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd31);
    #1;
    chk("restart_x20", rs1_out, 32'h0);
    chk("restart_x31", rs2_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_msrv32_integer_rf_wb
`default_nettype wire
